// File: rtl/fmult_accum_seq.sv
// rtl/fmult_accum_seq.sv - shares one FMULT across the eight predictor products and accumulates SEZ/SE
// Optional operand pipeline stage: define FMULT_SEQ_PIPE_EN.
module fmult_accum_seq #(
  parameter int NPROD = 8,
  parameter int NZERO = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  input  logic        start,
  input  logic [15:0] a1,
  input  logic [15:0] a2,
  input  logic [15:0] b1,
  input  logic [15:0] b2,
  input  logic [15:0] b3,
  input  logic [15:0] b4,
  input  logic [15:0] b5,
  input  logic [15:0] b6,
  input  logic [10:0] sr1,
  input  logic [10:0] sr2,
  input  logic [10:0] dq1,
  input  logic [10:0] dq2,
  input  logic [10:0] dq3,
  input  logic [10:0] dq4,
  input  logic [10:0] dq5,
  input  logic [10:0] dq6,
  output logic [15:0] anbn,
  output logic [10:0] srndqn,
  input  logic [15:0] wanwbn,
  output logic        busy,
  output logic        done,
  output logic [14:0] sez,
  output logic [14:0] se
);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

`ifdef FMULT_SEQ_PIPE_EN
  localparam logic [3:0] LAST_IDX = 4'(NPROD);
  localparam logic [3:0] SEZ_IDX  = 4'(NZERO);
`else
  localparam logic [3:0] LAST_IDX = 4'(NPROD - 1);
  localparam logic [3:0] SEZ_IDX  = 4'(NZERO - 1);
`endif
  localparam logic [3:0] NPROD_W  = 4'(NPROD);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [15:0] acc;
  logic [15:0] sezi_hold;
  logic [15:0] acc_sum;
  logic [15:0] sel_an;
  logic [10:0] sel_sr;
  logic        acc_en;

  // Scan chain is a simple gated pass-through in this block
  assign scan_out0 = test_mode & scan_enable & scan_in0;

  assign acc_sum = acc + wanwbn;

  always_comb begin
    sel_an = 16'h0000;
    sel_sr = 11'h000;
    case (idx)
      4'd0: begin sel_an = b1; sel_sr = dq1; end
      4'd1: begin sel_an = b2; sel_sr = dq2; end
      4'd2: begin sel_an = b3; sel_sr = dq3; end
      4'd3: begin sel_an = b4; sel_sr = dq4; end
      4'd4: begin sel_an = b5; sel_sr = dq5; end
      4'd5: begin sel_an = b6; sel_sr = dq6; end
      4'd6: begin sel_an = a1; sel_sr = sr1; end
      4'd7: begin sel_an = a2; sel_sr = sr2; end
      default: begin sel_an = 16'h0000; sel_sr = 11'h000; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = start ? MULT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FMULT_SEQ_PIPE_EN
  // Operands are registered, so the product for idx k returns while idx is k+1
  logic acc_vld;

  assign acc_en = (state == MULT) && acc_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      anbn    <= 16'h0000;
      srndqn  <= 11'h000;
      acc_vld <= 1'b0;
    end else if ((state == MULT) && (idx < NPROD_W)) begin
      anbn    <= sel_an;
      srndqn  <= sel_sr;
      acc_vld <= 1'b1;
    end else begin
      anbn    <= 16'h0000;
      srndqn  <= 11'h000;
      acc_vld <= 1'b0;
    end
  end
`else
  assign acc_en = (state == MULT);
  assign anbn   = ((state == MULT) && (idx < NPROD_W)) ? sel_an : 16'h0000;
  assign srndqn = ((state == MULT) && (idx < NPROD_W)) ? sel_sr : 11'h000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      acc       <= 16'h0000;
      sezi_hold <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      sez       <= 15'h0000;
      se        <= 15'h0000;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == MULT) begin
        idx <= idx + 4'd1;
        if (acc_en) begin
          acc <= acc_sum;
          if (idx == SEZ_IDX) sezi_hold <= acc_sum;
        end
      end else begin
        if (state == DONE) begin
          sez  <= sezi_hold[15:1];
          se   <= acc[15:1];
          done <= 1'b1;
          busy <= 1'b0;
        end
        if (start) begin
          idx  <= 4'd0;
          acc  <= 16'h0000;
          busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmult_accum_seq.sv
// tb/tb_fmult_accum_seq.sv - scoreboard bench for fmult_accum_seq with an FMULT stub/model
module tb_fmult_accum_seq;

`ifdef FMULT_SEQ_PIPE_EN
  localparam int LAT = 11;
  localparam int PERIOD = 10;
  localparam int OPOFF = 2;
`else
  localparam int LAT = 10;
  localparam int PERIOD = 9;
  localparam int OPOFF = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, scan_in0, scan_enable, test_mode, start;
  logic [15:0] a1, a2, b1, b2, b3, b4, b5, b6;
  logic [10:0] sr1, sr2, dq1, dq2, dq3, dq4, dq5, dq6;
  logic [15:0] anbn, wanwbn;
  logic [10:0] srndqn;
  logic        scan_out0, busy, done;
  logic [14:0] sez, se;

  logic [15:0] coef [8];
  logic [10:0] sig [8];
  int          stub_mode;
  logic [15:0] stub_const;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [14:0] sez;
    logic [14:0] se;
  } exp_t;
  exp_t sb[$];

  assign {b1, b2, b3, b4, b5, b6, a1, a2} = {coef[0], coef[1], coef[2], coef[3], coef[4], coef[5], coef[6], coef[7]};
  assign {dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2} = {sig[0], sig[1], sig[2], sig[3], sig[4], sig[5], sig[6], sig[7]};

  fmult_accum_seq dut (
    .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_enable(scan_enable),
    .test_mode(test_mode), .scan_out0(scan_out0), .start(start),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
    .sr1(sr1), .sr2(sr2), .dq1(dq1), .dq2(dq2), .dq3(dq3), .dq4(dq4), .dq5(dq5), .dq6(dq6),
    .anbn(anbn), .srndqn(srndqn), .wanwbn(wanwbn), .busy(busy), .done(done),
    .sez(sez), .se(se)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fmult(input logic [15:0] an, input logic [10:0] sr);
    logic [15:0] neg;
    logic [12:0] mag;
    int aexp, amant, wexp, wmant, wmag;
    neg = -an;
    mag = an[15] ? neg[14:2] : an[14:2];
    aexp = 0;
    for (int i = 0; i < 13; i++) if (mag[i]) aexp = i + 1;
    amant = (mag == 13'd0) ? 32 : ((int'(mag) << 6) >> aexp);
    wexp = int'(sr[9:6]) + aexp;
    wmant = (int'(sr[5:0]) * amant + 48) >> 4;
    wmag = (wexp > 26) ? ((wmant << 7) << (wexp - 26)) : ((wmant << 7) >> (26 - wexp));
    wmag = wmag & 32767;
    return (sr[10] ^ an[15]) ? 16'(-wmag) : 16'(wmag);
  endfunction

  function automatic logic [15:0] prod(input int k);
    case (stub_mode)
      0:       return 16'(k + 1);
      1:       return stub_const;
      default: return fmult(coef[k], sig[k]);
    endcase
  endfunction

  // FMULT stub: ramp mode identifies the product by its (distinct) coefficient
  always_comb begin
    wanwbn = 16'h0000;
    case (stub_mode)
      0: for (int k = 0; k < 8; k++) if (anbn != 16'h0000 && anbn == coef[k]) wanwbn = 16'(k + 1);
      1: wanwbn = stub_const;
      default: wanwbn = fmult(anbn, srndqn);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expected();
    logic [15:0] sum, sezi;
    exp_t e;
    sum = 16'h0000;
    sezi = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      sum = sum + prod(k);
      if (k == 5) sezi = sum;
    end
    e.sez = sezi[15:1];
    e.se = sum[15:1];
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sez", 32'(sez), 32'(e.sez));
      check("se", 32'(se), 32'(e.se));
    end
  endtask

  task automatic set_ramp_ops();
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'((k + 1) * 256 + k);
      sig[k] = 11'(64 + k * 3);
    end
  endtask

  task automatic run_one();
    int n;
    int k;
    bit got;
    push_expected();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    got = 1'b0;
    while (n <= 20 && !got) begin
      k = n - OPOFF;
      if (k >= 0 && k < 8) begin
        check($sformatf("anbn[%0d]", k), 32'(anbn), 32'(coef[k]));
        check($sformatf("srndqn[%0d]", k), 32'(srndqn), 32'(sig[k]));
      end
      if (done) begin
        got = 1'b1;
        check("latency", 32'(n), 32'(LAT));
        pop_compare();
      end else begin
        @(posedge clk);
        #1 n++;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last, pulses, done_seen;
    reset = 1'b1;
    start = 1'b0;
    scan_in0 = 1'b0;
    scan_enable = 1'b0;
    test_mode = 1'b0;
    stub_mode = 0;
    stub_const = 16'h0000;
    set_ramp_ops();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sez", 32'(sez), 32'd0);
    check("rst_se", 32'(se), 32'd0);
    check("rst_anbn", 32'(anbn), 32'd0);
    check("rst_srndqn", 32'(srndqn), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Ramp: expect sez=10, se=18
    stub_mode = 0;
    run_one();
    check("ramp_sez_abs", 32'(sez), 32'd10);
    check("ramp_se_abs", 32'(se), 32'd18);
    check("idle_anbn", 32'(anbn), 32'd0);

    // Negative products and 16-bit wrap-around
    stub_mode = 1;
    stub_const = 16'hFFFF;
    run_one();
    check("neg_sez_abs", 32'(sez), 32'h7FFD);
    stub_const = 16'h4000;
    run_one();
    check("wrap_sez_abs", 32'(sez), 32'h4000);
    check("wrap_se_abs", 32'(se), 32'h0000);

    // Start held high: one run per PERIOD, no mid-run acceptance
    stub_mode = 0;
    for (int r = 0; r < 4; r++) push_expected();
    @(negedge clk) start = 1'b1;
    n = 0;
    last = 0;
    pulses = 0;
    while (pulses < 4 && n < 60) begin
      @(posedge clk);
      #1 n++;
      if (done) begin
        pulses++;
        if (pulses == 1) check("b2b_first", 32'(n), 32'(LAT));
        else check("b2b_period", 32'(n - last), 32'(PERIOD));
        last = n;
        pop_compare();
        if (pulses == 3) start = 1'b0;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd4);
    repeat (2) @(posedge clk);

    // Reset during the 4th MULT cycle aborts and clears outputs
    stub_mode = 1;
    stub_const = 16'h0123;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sez", 32'(sez), 32'd0);
    check("abort_se", 32'(se), 32'd0);
    check("abort_anbn", 32'(anbn), 32'd0);
    @(negedge clk) reset = 1'b0;
    done_seen = 0;
    repeat (14) begin
      @(posedge clk);
      #1 if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    // Real FMULT model: all zero, then a single b1*dq1 term
    stub_mode = 2;
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'h0000;
      sig[k] = 11'h000;
    end
    run_one();
    coef[0] = 16'h4000;
    sig[0] = 11'h2A0;
    run_one();
    check("fmult_sez_abs", 32'(sez), 32'd536);
    check("fmult_se_abs", 32'(se), 32'd536);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmult_accum_seq.md
Name: fmult_accum_seq

Overview:
- Sequencer that shares one FMULT instance across the eight predictor products of a channel: six zero-section terms (B1..B6 × DQ1..DQ6) and two pole-section terms (A1,A2 × SR1,SR2).
- Steers operands onto the FMULT inputs one product per cycle and captures the returned WAnWBn.
- Accumulates the products into SEZI/SEI and emits SEZ/SE with a one-cycle done pulse.
- Sits between the adaptive predictor coefficient registers and the FMULT instance in the single-resource datapath.

Parameters:
- NPROD, 8, number of products per run. Fixed at 8; any other value is unsupported.
- NZERO, 6, number of zero-section products, issued first.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_in0  in  1  scan chain input
- scan_enable  in  1  scan shift enable
- test_mode  in  1  test mode select
- scan_out0  out  1  scan chain output
- start  in  1  single-cycle request to begin a run
- a1, a2  in  16 each  pole coefficients, two's complement
- b1..b6  in  16 each  zero coefficients, two's complement
- sr1, sr2  in  11 each  reconstructed signal, float format {sign, exp[3:0], mant[5:0]}
- dq1..dq6  in  11 each  quantized difference, same float format
- anbn  out  16  coefficient operand driven to FMULT
- srndqn  out  11  signal operand driven to FMULT
- wanwbn  in  16  product returned by FMULT, two's complement
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when sez/se are updated
- sez  out  15  zero-section estimate
- se  out  15  signal estimate

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: FSM=IDLE, idx=0, acc=0, sezi_hold=0, busy=0, done=0, sez=0, se=0, anbn=0, srndqn=0.
- FSM states: IDLE, MULT, DONE.
- IDLE: anbn and srndqn are 0.
  - start=1 at an edge → MULT with idx=0, acc=0, busy=1.
- Operand map by idx:
  - idx 0..5 → (b1,dq1)..(b6,dq6)
  - idx 6 → (a1,sr1)
  - idx 7 → (a2,sr2)
  - anbn/srndqn are combinational from idx in the base build.
- MULT: each cycle acc <= acc + wanwbn, 16-bit modulo with no saturation, and idx increments.
  - At the edge closing idx=5, sezi_hold <= acc + wanwbn.
  - At the edge closing idx=7 → DONE.
- DONE: lasts one cycle.
  - sez <= sezi_hold[15:1], se <= acc[15:1]. This is an arithmetic >>1 truncated to 15 bits.
  - done=1, busy=0 → IDLE.
  - start is honoured in the same cycle as DONE: it goes directly to MULT, and done still pulses.
- Latency: done is high exactly 10 cycles after the edge that samples start (8 MULT cycles + 1 DONE cycle after the IDLE sampling edge). Back-to-back throughput is one run per 9 cycles.
- sez and se hold their values until the next DONE.
- Input stability: a*/b*/sr*/dq* must be stable from start until done. The block does not latch them.
- start during MULT is ignored, with no queuing.
- reset asserted mid-run aborts immediately to the reset values; sez/se are cleared.
- wanwbn is sampled only in MULT. Its value in other states is don't-care.

Optional Feature:
- FMULT_SEQ_PIPE_EN
- Defined:
  - anbn and srndqn are registered, so FMULT sees the operand one cycle after idx selects it.
  - MULT lasts 9 cycles; the first capture is skipped (a valid flag delays accumulation by one cycle).
  - done arrives 11 cycles after the start edge, and the back-to-back period is 10 cycles.
- Undefined: combinational operand mux as above.
- Results are identical in both builds.

Test Plan:
- Reset check: assert reset for 2 cycles → busy=0, done=0, sez=0, se=0, anbn=0.
- Ramp products: FMULT stub returns k+1 for idx k; pulse start → operand sequence b1/dq1..b6/dq6, a1/sr1, a2/sr2; done at start+10; sez=10, se=18.
- Negative products: stub returns 0xFFFF for every idx → sez=0x7FFD (-3), se=0x7FFC (-4).
- Wrap-around: stub returns 0x4000 for every idx → sezi=0x8000 so sez=0x4000; sei=0x0000 so se=0.
- Start rules: start held high continuously → done pulses every 9 cycles and no start is accepted mid-run. Reset at the 4th MULT cycle → idle next cycle, no done, sez=se=0.
- Real FMULT: all inputs 0 → se=sez=0. b1=0x4000, dq1=0x2A0 (exp=10, mant=32), rest 0 → sez and se match the golden FMULT/ACCUM model value.
